// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: turns rising edges of the divided clock into single-cycle CPU
// enable pulses, under run / single-step / sticky-halt control.
module cpu_step_ctrl #(
    parameter int DEBOUNCE_N = 500000,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_div,
    input  logic             btn_step,
    input  logic             run_sw,
    input  logic             halt,
    output logic             cpu_en,
    output logic [1:0]       mode,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int DB_W = $clog2(DEBOUNCE_N);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_N - 1);

    typedef enum logic [1:0] {
        ST_PAUSE = 2'd0,
        ST_RUN   = 2'd1,
        ST_STEP  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    logic            btn_meta_r;
    logic            btn_s_r;
    logic            run_meta_r;
    logic            run_s_r;
    logic            btn_db_r;
    logic            btn_db_q_r;
    logic [DB_W-1:0] db_cnt_r;
    logic            clk_div_q_r;
    state_t          state_r;
    state_t          state_nxt_s;
    logic            pulse_s;
    logic            tick_s;
    logic            btn_press_s;
    logic            cpu_en_r;
    logic [CNT_W-1:0] cycle_count_r;

    // Two-flop synchronisers for the asynchronous board controls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_meta_r <= 1'b0;
            btn_s_r    <= 1'b0;
            run_meta_r <= 1'b0;
            run_s_r    <= 1'b0;
        end else begin
            btn_meta_r <= btn_step;
            btn_s_r    <= btn_meta_r;
            run_meta_r <= run_sw;
            run_s_r    <= run_meta_r;
        end
    end

    // Debounce: a new button level is accepted after DEBOUNCE_N consecutive differing cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_db_r   <= 1'b0;
            btn_db_q_r <= 1'b0;
            db_cnt_r   <= {DB_W{1'b0}};
        end else begin
            btn_db_q_r <= btn_db_r;
            if (btn_s_r != btn_db_r) begin
                if (db_cnt_r == DB_LAST) begin
                    btn_db_r <= btn_s_r;
                    db_cnt_r <= {DB_W{1'b0}};
                end else begin
                    db_cnt_r <= db_cnt_r + DB_W'(1);
                end
            end else begin
                db_cnt_r <= {DB_W{1'b0}};
            end
        end
    end

    // Resetting the edge history to 1 suppresses a false tick when clk_div is high at release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_div_q_r <= 1'b1;
        end else begin
            clk_div_q_r <= clk_div;
        end
    end

    assign tick_s      = clk_div & ~clk_div_q_r;
    assign btn_press_s = btn_db_r & ~btn_db_q_r;

    // Next-state and pulse decision; halt wins in every state but HALT itself.
    always_comb begin
        state_nxt_s = state_r;
        pulse_s     = 1'b0;
        case (state_r)
            ST_PAUSE: begin
                if (halt) begin
                    state_nxt_s = ST_HALT;
                end else if (run_s_r) begin
                    state_nxt_s = ST_RUN;
                end else if (btn_press_s) begin
                    state_nxt_s = ST_STEP;
                end else begin
                    state_nxt_s = ST_PAUSE;
                end
            end
            ST_RUN: begin
                if (halt) begin
                    state_nxt_s = ST_HALT;
                end else if (tick_s) begin
                    pulse_s     = 1'b1;
                    state_nxt_s = run_s_r ? ST_RUN : ST_PAUSE;
                end else if (!run_s_r) begin
                    state_nxt_s = ST_PAUSE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_STEP: begin
                if (halt) begin
                    state_nxt_s = ST_HALT;
                end else if (tick_s) begin
                    pulse_s     = 1'b1;
                    state_nxt_s = ST_PAUSE;
                end else begin
                    state_nxt_s = ST_STEP;
                end
            end
            ST_HALT: begin
                state_nxt_s = ST_HALT;
            end
            default: begin
                state_nxt_s = ST_PAUSE;
            end
        endcase
    end

    // State, enable pulse and pulse counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_PAUSE;
            cpu_en_r      <= 1'b0;
            cycle_count_r <= {CNT_W{1'b0}};
        end else begin
            state_r  <= state_nxt_s;
            cpu_en_r <= pulse_s;
            if (cpu_en_r) begin
                cycle_count_r <= cycle_count_r + CNT_W'(1);
            end else begin
                cycle_count_r <= cycle_count_r;
            end
        end
    end

    assign cpu_en      = cpu_en_r;
    assign mode        = state_r;
    assign cycle_count = cycle_count_r;

endmodule
